// File: rtl/regfile_bypass_sb.sv
// ============================================================================
// Module   : regfile_bypass_sb
// Purpose  : ID-stage register file with write bypass, clear sequencer and
//            pending-write scoreboard for RAW hazard detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_bypass_sb #(
  parameter int XLEN           = 32,
  parameter int NREG           = 32,
  localparam int ADDR_W        = $clog2(NREG),
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] src_one,
  input  logic [ADDR_W-1:0] src_two,
  output logic [XLEN-1:0]   out_one,
  output logic [XLEN-1:0]   out_two,
  input  logic [ADDR_W-1:0] dest,
  input  logic              write_enable,
  input  logic [XLEN-1:0]   data_in,
  input  logic              rsv_enable,
  input  logic [ADDR_W-1:0] rsv_dest,
  output logic              busy_one,
  output logic              busy_two,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] c_last_reg = ADDR_W'(NREG - 1);
  localparam logic [ADDR_W-1:0] c_first_reg = ADDR_W'(1);
  localparam logic [NREG-1:0]   c_one_hot0 = NREG'(1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [XLEN-1:0]   r_regs [NREG];
  logic [NREG-1:0]   r_pending;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_clr;
  logic              w_ready;
  logic              w_fwd_one;
  logic              w_fwd_two;

  assign w_ready = (r_state == S_RUN);
  assign ready   = w_ready;

  always_ff @(posedge clk) begin
    r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (reset) begin
      w_state_next = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
    end else if (r_state == S_CLEAR && r_cnt == c_last_reg) begin
      w_state_next = S_RUN;
    end
  end

  // x0 is never stored, so the sweep starts at register 1
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= c_first_reg;
    end else if (r_state == S_CLEAR) begin
      r_cnt <= r_cnt + c_first_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_CLEAR) begin
        r_regs[r_cnt] <= '0;
      end else if (write_enable && dest != '0) begin
        r_regs[dest] <= data_in;
      end
    end
  end

  // Set is OR-ed in after the clear so a new reservation supersedes a completing write
  assign w_set = (rsv_enable && rsv_dest != '0) ? (c_one_hot0 << rsv_dest) : '0;
  assign w_clr = write_enable ? (c_one_hot0 << dest) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else if (w_ready) begin
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  assign w_fwd_one = (BYPASS != 0) && write_enable && (dest == src_one);
  assign w_fwd_two = (BYPASS != 0) && write_enable && (dest == src_two);

  always_comb begin
    out_one  = '0;
    out_two  = '0;
    busy_one = 1'b0;
    busy_two = 1'b0;
    if (w_ready && src_one != '0) begin
      out_one  = w_fwd_one ? data_in : r_regs[src_one];
      busy_one = !w_fwd_one && r_pending[src_one];
    end
    if (w_ready && src_two != '0) begin
      out_two  = w_fwd_two ? data_in : r_regs[src_two];
      busy_two = !w_fwd_two && r_pending[src_two];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_bypass_sb.sv
// ============================================================================
// Module   : tb_regfile_bypass_sb
// Purpose  : Bench for regfile_bypass_sb; two builds (bypass+clear, no bypass
//            + preserve) driven in parallel and compared to a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_bypass_sb;

  localparam int NREG = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  src_one, src_two, dest, rsv_dest;
  logic        write_enable, rsv_enable;
  logic [31:0] data_in;

  logic [31:0] a_out_one, a_out_two, b_out_one, b_out_two;
  logic        a_busy_one, a_busy_two, a_ready;
  logic        b_busy_one, b_busy_two, b_ready;

  always #5 clk = ~clk;

  regfile_bypass_sb #(.XLEN(32), .NREG(32), .BYPASS(1), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .reset(reset), .src_one(src_one), .src_two(src_two),
    .out_one(a_out_one), .out_two(a_out_two), .dest(dest),
    .write_enable(write_enable), .data_in(data_in), .rsv_enable(rsv_enable),
    .rsv_dest(rsv_dest), .busy_one(a_busy_one), .busy_two(a_busy_two), .ready(a_ready)
  );

  regfile_bypass_sb #(.XLEN(32), .NREG(32), .BYPASS(0), .CLEAR_ON_RESET(0)) u_b (
    .clk(clk), .reset(reset), .src_one(src_one), .src_two(src_two),
    .out_one(b_out_one), .out_two(b_out_two), .dest(dest),
    .write_enable(write_enable), .data_in(data_in), .rsv_enable(rsv_enable),
    .rsv_dest(rsv_dest), .busy_one(b_busy_one), .busy_two(b_busy_two), .ready(b_ready)
  );

  // Reference model: index 0 = build a, index 1 = build b
  bit          m_byp [2] = '{1'b1, 1'b0};
  bit          m_cor [2] = '{1'b1, 1'b0};
  logic [31:0] m_reg [2][NREG];
  bit          m_pend [2][NREG];
  bit          m_valid [2][NREG];
  int          m_left [2];
  bit          m_init [2];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit rdy(input int k);
    return m_init[k] && (m_left[k] == 0);
  endfunction

  task automatic check_port(input int k, input string tag_o, input string tag_b,
                            input logic [4:0] s, input logic [31:0] o, input logic b);
    logic [31:0] eo;
    logic        eb;
    bit          known;
    known = 1'b1;
    if (!rdy(k) || s == 5'd0) begin
      eo = 32'd0; eb = 1'b0;
    end else if (m_byp[k] && write_enable && dest == s) begin
      eo = data_in; eb = 1'b0;
    end else begin
      eo = m_reg[k][s]; eb = m_pend[k][s]; known = m_valid[k][s];
    end
    if (known) chk(tag_o, o, eo);
    chk(tag_b, {31'd0, b}, {31'd0, eb});
  endtask

  task automatic check_inst(input int k, input string nm, input logic [31:0] o1,
                            input logic [31:0] o2, input logic b1, input logic b2,
                            input logic r);
    if (!m_init[k]) return;
    chk({nm, "_ready"}, {31'd0, r}, {31'd0, rdy(k)});
    check_port(k, {nm, "_out_one"}, {nm, "_busy_one"}, src_one, o1, b1);
    check_port(k, {nm, "_out_two"}, {nm, "_busy_two"}, src_two, o2, b2);
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_init[k] = 1'b1;
        m_left[k] = m_cor[k] ? NREG - 1 : 0;
        for (int i = 0; i < NREG; i++) m_pend[k][i] = 1'b0;
      end else if (m_init[k] && m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          for (int i = 0; i < NREG; i++) begin
            m_reg[k][i] = 32'd0; m_valid[k][i] = 1'b1;
          end
        end
      end else if (m_init[k]) begin
        if (write_enable && dest != 5'd0) begin
          m_reg[k][dest] = data_in; m_valid[k][dest] = 1'b1;
        end
        if (write_enable) m_pend[k][dest] = 1'b0;
        if (rsv_enable && rsv_dest != 5'd0) m_pend[k][rsv_dest] = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_inst(0, "a", a_out_one, a_out_two, a_busy_one, a_busy_two, a_ready);
    check_inst(1, "b", b_out_one, b_out_two, b_busy_one, b_busy_two, b_ready);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_inputs(input bit narrow);
    src_one      = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
    src_two      = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
    dest         = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
    rsv_dest     = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
    write_enable = ($urandom_range(0, 1) == 1);
    rsv_enable   = ($urandom_range(0, 2) == 0);
    data_in      = $urandom;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_init[k] = 1'b0; m_left[k] = 0;
      for (int i = 0; i < NREG; i++) begin
        m_reg[k][i] = 32'd0; m_pend[k][i] = 1'b0; m_valid[k][i] = (i == 0);
      end
    end
    reset = 1'b1; src_one = '0; src_two = '0; dest = '0; rsv_dest = '0;
    write_enable = 1'b0; rsv_enable = 1'b0; data_in = '0;
    step(); step();
    reset = 1'b0;
    repeat (32) step();

    // Fill every register so the preserve-on-reset build has known contents
    for (int i = 1; i < NREG; i++) begin
      write_enable = 1'b1; dest = 5'(i); data_in = $urandom; src_two = 5'(i);
      step();
    end
    write_enable = 1'b0;

    // Preload reg5, reset once, then compare clearing vs preserving builds
    write_enable = 1'b1; dest = 5'd5; data_in = 32'hDEADBEEF; step();
    write_enable = 1'b0; src_one = 5'd5; step();
    reset = 1'b1; step();
    reset = 1'b0;
    repeat (31) step();
    chk("a_reg5_cleared", a_out_one, 32'd0);
    chk("b_reg5_kept", b_out_one, 32'hDEADBEEF);
    chk("a_ready_after_31", {31'd0, a_ready}, 32'd1);
    step();

    // x0 writes and reservations
    write_enable = 1'b1; dest = 5'd0; data_in = 32'h12345678; src_one = 5'd0; step();
    write_enable = 1'b0; step();
    rsv_enable = 1'b1; rsv_dest = 5'd0; step();
    rsv_enable = 1'b0; step();

    // Write with same-cycle read of the destination
    write_enable = 1'b1; dest = 5'd7; data_in = 32'hA5A5A5A5; src_two = 5'd7; step();
    write_enable = 1'b0; step();

    // RAW hazard on reg3
    rsv_enable = 1'b1; rsv_dest = 5'd3; step();
    rsv_enable = 1'b0; src_one = 5'd3; step();
    write_enable = 1'b1; dest = 5'd3; data_in = 32'h55; step();
    write_enable = 1'b0; step();

    // Simultaneous set and clear on reg9
    rsv_enable = 1'b1; rsv_dest = 5'd9; step();
    write_enable = 1'b1; dest = 5'd9; data_in = 32'h0BADF00D; src_one = 5'd9; step();
    write_enable = 1'b0; rsv_enable = 1'b0; step();
    chk("a_busy9_after_setclr", {31'd0, a_busy_one}, 32'd1);
    step();

    // Reset mid-clear with write/reserve attempts during the sweep
    reset = 1'b1; step();
    reset = 1'b0;
    repeat (9) begin rand_inputs(1'b0); step(); end
    reset = 1'b1; rand_inputs(1'b0); step();
    reset = 1'b0;
    repeat (31) begin rand_inputs(1'b1); step(); end
    write_enable = 1'b0; rsv_enable = 1'b0; step();

    // Random traffic with occasional resets
    repeat (3000) begin
      rand_inputs($urandom_range(0, 1) == 1);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; write_enable = 1'b0; rsv_enable = 1'b0;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
